// File: rtl/proc_ctrl_unit_pkg.sv
// Shared types and constants for the multi-cycle processor control unit.
// Imported by the decoder, the control FSM and the testbench.
package proc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP,
    C_ALU,
    C_LOAD,
    C_STORE,
    C_BEQ,
    C_JMP,
    C_HALT,
    C_ILLEGAL
  } op_class_t;

  localparam int OP_NOP    = 0;
  localparam int OP_ALU_LO = 1;
  localparam int OP_ALU_HI = 31;
  localparam int OP_LOAD   = 32;
  localparam int OP_STORE  = 33;
  localparam int OP_BEQ    = 34;
  localparam int OP_JMP    = 35;
  localparam int OP_HALT   = 63;

  localparam logic [1:0] MUX_MEM = 2'd0;
  localparam logic [1:0] MUX_ALU = 2'd1;
  localparam logic [1:0] MUX_IMM = 2'd2;
  localparam logic [1:0] MUX_PC  = 2'd3;

endpackage

// File: rtl/proc_ctrl_unit_if.sv
// Handshake bundle between the instruction parser/datapath and the control FSM.
// The slave side is the control unit; the master side drives opcode and flags.
interface proc_ctrl_unit_if #(
  parameter int OPW        = 6,
  parameter int MUX_SEL_SZ = 2,
  parameter int CNT_WIDTH  = 32
);
  logic                  i_run;
  logic [OPW-1:0]        i_opcd;
  logic                  i_alu_zero;
  logic                  o_ir_e;
  logic                  o_pc_e;
  logic                  o_ld_pc;
  logic                  o_mem_we;
  logic                  o_rf_we;
  logic [MUX_SEL_SZ-1:0] o_mux_sel;
  logic                  o_addr_sel;
  logic [OPW-1:0]        o_alu_op;
  logic                  o_halt;
  logic                  o_illegal;
  logic [CNT_WIDTH-1:0]  o_ret_cnt;

  modport master (
    output i_run, i_opcd, i_alu_zero,
    input  o_ir_e, o_pc_e, o_ld_pc, o_mem_we, o_rf_we, o_mux_sel,
           o_addr_sel, o_alu_op, o_halt, o_illegal, o_ret_cnt
  );

  modport slave (
    input  i_run, i_opcd, i_alu_zero,
    output o_ir_e, o_pc_e, o_ld_pc, o_mem_we, o_rf_we, o_mux_sel,
           o_addr_sel, o_alu_op, o_halt, o_illegal, o_ret_cnt
  );
endinterface

// File: rtl/proc_ctrl_unit_op_decode.sv
// Combinational opcode-to-class decoder; anything not explicitly defined is illegal.
module proc_op_decode
  import proc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcd,
  output op_class_t      op_class
);

  int opv;

  always_comb begin
    opv      = int'(opcd);
    op_class = C_ILLEGAL;
    if (opv == OP_NOP)                           op_class = C_NOP;
    else if (opv >= OP_ALU_LO && opv <= OP_ALU_HI) op_class = C_ALU;
    else if (opv == OP_LOAD)                     op_class = C_LOAD;
    else if (opv == OP_STORE)                    op_class = C_STORE;
    else if (opv == OP_BEQ)                      op_class = C_BEQ;
    else if (opv == OP_JMP)                      op_class = C_JMP;
    else if (opv == OP_HALT)                     op_class = C_HALT;
  end

endmodule

// File: rtl/proc_ctrl_unit.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback sequencing with a
// memory-latency wait counter and a retired-instruction counter.
module proc_ctrl_unit
  import proc_pkg::*;
#(
  parameter int ISA_DPTH   = 64,
  parameter int MUX_SEL_SZ = 2,
  parameter int MEM_LAT    = 1,
  parameter int CNT_WIDTH  = 32
) (
  input logic             clk,
  input logic             rst_n,
  proc_ctrl_unit_if.slave bus
);

  localparam int OPW = $clog2(ISA_DPTH);

  state_t               state, state_next;
  logic [2:0]           wcnt;
  logic [OPW-1:0]       alu_op;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] ret_cnt;
  logic                 retire;
  state_t               boundary;
  op_class_t            dec_class, exec_class;

  logic       ir_e, pc_e, ld_pc, mem_we, rf_we, addr_sel, halt;
  logic [1:0] mux_sel;

  proc_op_decode #(.OPW(OPW)) u_dec_in   (.opcd(bus.i_opcd), .op_class(dec_class));
  proc_op_decode #(.OPW(OPW)) u_dec_exec (.opcd(alu_op),     .op_class(exec_class));

  // Wait counter reloads on every state change so FETCH and LOAD-MEM each last MEM_LAT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) wcnt <= 3'(MEM_LAT - 1);
      else if (wcnt != '0)     wcnt <= wcnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op  <= '0;
      illegal <= 1'b0;
      ret_cnt <= '0;
    end else begin
      if (state == S_DECODE) alu_op <= bus.i_opcd;
      if (state == S_DECODE && dec_class == C_ILLEGAL) illegal <= 1'b1;
      if (retire) ret_cnt <= ret_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    boundary   = bus.i_run ? S_FETCH : S_IDLE;
    case (state)
      S_IDLE:  if (bus.i_run) state_next = S_FETCH;
      S_FETCH: if (wcnt == '0) state_next = S_DECODE;
      S_DECODE: begin
        case (dec_class)
          C_NOP:     begin retire = 1'b1; state_next = boundary; end
          C_HALT:    begin retire = 1'b1; state_next = S_HALT;   end
          C_ILLEGAL: state_next = S_HALT;
          default:   state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (exec_class)
          C_ALU:           state_next = S_WB;
          C_LOAD, C_STORE: state_next = S_MEM;
          default:         begin retire = 1'b1; state_next = boundary; end
        endcase
      end
      S_MEM: begin
        if (exec_class == C_STORE) begin
          retire     = 1'b1;
          state_next = boundary;
        end else if (wcnt == '0) begin
          state_next = S_WB;
        end
      end
      S_WB:    begin retire = 1'b1; state_next = boundary; end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs, except the BEQ branch which passes the ALU zero flag straight through
  always_comb begin
    ir_e     = 1'b0;
    pc_e     = 1'b0;
    ld_pc    = 1'b0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    addr_sel = 1'b0;
    halt     = 1'b0;
    mux_sel  = MUX_MEM;
    case (state)
      S_FETCH: if (wcnt == '0) begin ir_e = 1'b1; pc_e = 1'b1; end
      S_EXEC: begin
        if (exec_class == C_BEQ)      ld_pc = bus.i_alu_zero;
        else if (exec_class == C_JMP) ld_pc = 1'b1;
      end
      S_MEM: begin
        addr_sel = 1'b1;
        if (exec_class == C_STORE) mem_we = 1'b1;
      end
      S_WB: begin
        rf_we = 1'b1;
        if (exec_class == C_ALU) mux_sel = MUX_ALU;
      end
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_ir_e     = ir_e;
  assign bus.o_pc_e     = pc_e;
  assign bus.o_ld_pc    = ld_pc;
  assign bus.o_mem_we   = mem_we;
  assign bus.o_rf_we    = rf_we;
  assign bus.o_mux_sel  = MUX_SEL_SZ'(mux_sel);
  assign bus.o_addr_sel = addr_sel;
  assign bus.o_alu_op   = alu_op;
  assign bus.o_halt     = halt;
  assign bus.o_illegal  = illegal;
  assign bus.o_ret_cnt  = ret_cnt;

endmodule

// File: tb/tb_proc_ctrl_unit.sv
// Scoreboard bench: two control units (MEM_LAT=3 / 32-bit count and MEM_LAT=1 / 3-bit count)
// driven with directed instruction sequences; expected per-cycle outputs are queued and checked.
module tb_proc_ctrl_unit;

  typedef struct packed {
    logic        ir_e;
    logic        pc_e;
    logic        ld_pc;
    logic        mem_we;
    logic        rf_we;
    logic [1:0]  mux;
    logic        addr;
    logic [5:0]  alu_op;
    logic        halt;
    logic        illegal;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;

  proc_ctrl_unit_if #(.OPW(6), .MUX_SEL_SZ(2), .CNT_WIDTH(32)) bus_a ();
  proc_ctrl_unit_if #(.OPW(6), .MUX_SEL_SZ(2), .CNT_WIDTH(3))  bus_b ();

  proc_ctrl_unit #(.ISA_DPTH(64), .MUX_SEL_SZ(2), .MEM_LAT(3), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(bus_a)
  );
  proc_ctrl_unit #(.ISA_DPTH(64), .MUX_SEL_SZ(2), .MEM_LAT(1), .CNT_WIDTH(3)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          tests = 0;
  int          fails = 0;
  int          lat[2]    = '{3, 1};
  logic [31:0] m_mask[2] = '{32'hFFFF_FFFF, 32'h0000_0007};
  logic [5:0]  m_op[2];
  logic        m_ill[2];
  logic [31:0] m_cnt[2];

  function automatic exp_t sample(input int id);
    exp_t s;
    if (id == 0) begin
      s = {bus_a.o_ir_e, bus_a.o_pc_e, bus_a.o_ld_pc, bus_a.o_mem_we, bus_a.o_rf_we,
           bus_a.o_mux_sel, bus_a.o_addr_sel, bus_a.o_alu_op, bus_a.o_halt,
           bus_a.o_illegal, bus_a.o_ret_cnt};
    end else begin
      s = {bus_b.o_ir_e, bus_b.o_pc_e, bus_b.o_ld_pc, bus_b.o_mem_we, bus_b.o_rf_we,
           bus_b.o_mux_sel, bus_b.o_addr_sel, bus_b.o_alu_op, bus_b.o_halt,
           bus_b.o_illegal, 32'(bus_b.o_ret_cnt)};
    end
    return s;
  endfunction

  task automatic check_output(input string name, input exp_t act, input exp_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got ir=%b pc=%b ld=%b we=%b rf=%b mux=%0d addr=%b op=%0d halt=%b ill=%b cnt=%0d, expected ir=%b pc=%b ld=%b we=%b rf=%b mux=%0d addr=%b op=%0d halt=%b ill=%b cnt=%0d",
               name, $time, act.ir_e, act.pc_e, act.ld_pc, act.mem_we, act.rf_we, act.mux,
               act.addr, act.alu_op, act.halt, act.illegal, act.cnt,
               exp.ir_e, exp.pc_e, exp.ld_pc, exp.mem_we, exp.rf_we, exp.mux,
               exp.addr, exp.alu_op, exp.halt, exp.illegal, exp.cnt);
    end
  endtask

  // Monitors: one expected entry is consumed per cycle while a sequence is outstanding
  always @(negedge clk) begin
    if (q_a.size() != 0) begin
      exp_t e;
      e = q_a.pop_front();
      check_output("dut_a cycle", sample(0), e);
    end
  end

  always @(negedge clk) begin
    if (q_b.size() != 0) begin
      exp_t e;
      e = q_b.pop_front();
      check_output("dut_b cycle", sample(1), e);
    end
  end

  task automatic push(input int id, input exp_t e);
    if (id == 0) q_a.push_back(e);
    else         q_b.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_run(input int id, input logic run);
    if (id == 0) bus_a.i_run = run;
    else         bus_b.i_run = run;
  endtask

  task automatic drive_op(input int id, input int op, input logic zero);
    if (id == 0) begin bus_a.i_opcd = 6'(op); bus_a.i_alu_zero = zero; end
    else         begin bus_b.i_opcd = 6'(op); bus_b.i_alu_zero = zero; end
  endtask

  function automatic exp_t base_exp(input int id);
    exp_t b;
    b         = '0;
    b.alu_op  = m_op[id];
    b.illegal = m_ill[id];
    b.cnt     = m_cnt[id];
    return b;
  endfunction

  // Queue the expected trace for one instruction and run it; cut>0 stops after that many cycles
  task automatic apply_stimulus(input int id, input int op, input logic zero,
                                input logic run_after, input logic from_idle, input int cut);
    exp_t base, e;
    int   n;
    int   L;
    logic [31:0] next_cnt;
    L = lat[id];
    base = base_exp(id);
    if (from_idle) begin
      push(id, base);
      drive_run(id, 1'b1);
      step(1);
    end
    drive_op(id, op, zero);
    n = 0;
    for (int j = 0; j < L; j++) begin
      e = base;
      if (j == L - 1) begin e.ir_e = 1'b1; e.pc_e = 1'b1; end
      push(id, e);
      n++;
    end
    push(id, base);
    n++;
    base.alu_op = 6'(op);
    m_op[id]    = 6'(op);
    next_cnt    = (m_cnt[id] + 32'd1) & m_mask[id];
    if (op == 63) begin
      for (int j = 0; j < 4; j++) begin
        e = base; e.halt = 1'b1; e.cnt = next_cnt;
        push(id, e);
        n++;
      end
      m_cnt[id] = next_cnt;
    end else if (op >= 36) begin
      m_ill[id] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        e = base; e.halt = 1'b1; e.illegal = 1'b1;
        push(id, e);
        n++;
      end
    end else begin
      if (op != 0) begin
        e = base;
        if (op == 34) e.ld_pc = zero;
        if (op == 35) e.ld_pc = 1'b1;
        push(id, e);
        n++;
        if (op == 32) begin
          for (int j = 0; j < L; j++) begin
            e = base; e.addr = 1'b1;
            push(id, e);
            n++;
          end
        end
        if (op == 33) begin
          e = base; e.addr = 1'b1; e.mem_we = 1'b1;
          push(id, e);
          n++;
        end
        if (op <= 32) begin
          e = base; e.rf_we = 1'b1; e.mux = (op == 32) ? 2'd0 : 2'd1;
          push(id, e);
          n++;
        end
      end
      m_cnt[id] = next_cnt;
    end
    if (cut > 0) begin
      step(cut);
    end else begin
      step(n - 1);
      drive_run(id, run_after);
      step(1);
    end
  endtask

  task automatic expect_idle(input int id, input int n);
    drive_run(id, 1'b0);
    for (int j = 0; j < n; j++) push(id, base_exp(id));
    step(n);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear before the next edge
  task automatic do_reset(input int id);
    if (id == 0) q_a.delete();
    else         q_b.delete();
    drive_run(id, 1'b0);
    if (id == 0) rst_a = 1'b0;
    else         rst_b = 1'b0;
    #1;
    check_output("async reset", sample(id), '0);
    m_op[id] = '0; m_ill[id] = 1'b0; m_cnt[id] = '0;
    for (int j = 0; j < 3; j++) push(id, '0);
    step(2);
    if (id == 0) rst_a = 1'b1;
    else         rst_b = 1'b1;
    step(1);
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 2; i++) begin m_op[i] = '0; m_ill[i] = 1'b0; m_cnt[i] = '0; end
    drive_run(0, 1'b0); drive_op(0, 0, 1'b0);
    drive_run(1, 1'b0); drive_op(1, 0, 1'b0);
    @(posedge clk);
    #1;
    check_output("reset state a", sample(0), '0);
    check_output("reset state b", sample(1), '0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // MEM_LAT=1: ALU op then eight retirements wrap the 3-bit counter back to 0
    apply_stimulus(1, 5, 1'b0, 1'b1, 1'b1, 0);
    for (int k = 0; k < 7; k++) apply_stimulus(1, 0, 1'b0, (k != 6), 1'b0, 0);
    expect_idle(1, 3);

    // MEM_LAT=3: back-to-back instruction mix, i_run dropped during the final ALU op
    apply_stimulus(0, 32, 1'b0, 1'b1, 1'b1, 0);
    apply_stimulus(0, 33, 1'b0, 1'b1, 1'b0, 0);
    apply_stimulus(0, 34, 1'b0, 1'b1, 1'b0, 0);
    apply_stimulus(0, 34, 1'b1, 1'b1, 1'b0, 0);
    apply_stimulus(0, 35, 1'b0, 1'b1, 1'b0, 0);
    apply_stimulus(0, 0,  1'b0, 1'b1, 1'b0, 0);
    apply_stimulus(0, 31, 1'b0, 1'b0, 1'b0, 0);
    expect_idle(0, 3);

    apply_stimulus(0, 32, 1'b0, 1'b1, 1'b1, 6);
    do_reset(0);

    apply_stimulus(0, 40, 1'b1, 1'b1, 1'b1, 0);
    do_reset(0);
    apply_stimulus(0, 1, 1'b0, 1'b1, 1'b1, 0);
    apply_stimulus(0, 63, 1'b0, 1'b1, 1'b0, 0);

    step(2);
    tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard drain: %0d/%0d entries left, expected 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
